// File: rtl/run_window_ctrl.sv
// Run-length window controller: counts 0-runs and 1-runs reaching a programmed length
// within a window of valid samples. Optional abort input under `RUN_WINDOW_ABORT_EN`.
module run_window_ctrl #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic [CNT_W-1:0] win_len,
  input  logic             x,
  input  logic             x_valid,
`ifdef RUN_WINDOW_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             level,
  output logic             hit,
  output logic             hit_val,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] one_cnt,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] rl_q;
  logic [LEN_W-1:0] run_cnt;
  logic [LEN_W-1:0] run_nxt;
  logic [CNT_W-1:0] wl_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_nxt;
  logic             last_bit;
  logic             run_hit;
  logic             start_ok;
  logic             abort_req;

`ifdef RUN_WINDOW_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    run_nxt = run_cnt;
    if (run_cnt == '0 || x != last_bit)
      run_nxt = LEN_W'(1);
    else if (run_cnt < rl_q)
      run_nxt = run_cnt + 1'b1;
    bit_nxt  = bit_cnt + 1'b1;
    // run_len >= 2 guarantees a fresh run (count 1) can never look like a hit
    run_hit  = (run_nxt == rl_q) && (run_cnt != rl_q);
    start_ok = (run_len >= LEN_W'(2)) && (win_len != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rl_q     <= '0;
      wl_q     <= '0;
      run_cnt  <= '0;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      busy     <= 1'b0;
      level    <= 1'b0;
      hit      <= 1'b0;
      hit_val  <= 1'b0;
      zero_cnt <= '0;
      one_cnt  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              rl_q     <= run_len;
              wl_q     <= win_len;
              zero_cnt <= '0;
              one_cnt  <= '0;
              bit_cnt  <= '0;
              run_cnt  <= '0;
              last_bit <= 1'b0;
              level    <= 1'b0;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
            level <= 1'b0;
          end else if (x_valid) begin
            bit_cnt  <= bit_nxt;
            run_cnt  <= run_nxt;
            last_bit <= x;
            level    <= (run_nxt >= rl_q);
            if (run_hit) begin
              hit     <= 1'b1;
              hit_val <= x;
              if (x) begin
                if (one_cnt != '1) one_cnt <= one_cnt + 1'b1;
              end else begin
                if (zero_cnt != '1) zero_cnt <= zero_cnt + 1'b1;
              end
            end
            // final sample is still fully processed; only level/busy are forced low
            if (bit_nxt == wl_q) begin
              state <= DONE;
              busy  <= 1'b0;
              level <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_window_ctrl.sv
// Self-checking bench for run_window_ctrl: directed scenarios plus randomized windows
// compared cycle by cycle against a run-length reference model.
module tb_run_window_ctrl;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic [CNT_W-1:0] win_len;
  logic             x;
  logic             x_valid;
`ifdef RUN_WINDOW_ABORT_EN
  logic             abort;
`endif
  logic             busy, level, hit, hit_val, done, err;
  logic [CNT_W-1:0] zero_cnt, one_cnt;

  run_window_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len), .win_len(win_len),
    .x(x), .x_valid(x_valid),
`ifdef RUN_WINDOW_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .level(level), .hit(hit), .hit_val(hit_val),
    .zero_cnt(zero_cnt), .one_cnt(one_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: mode 0 idle, 1 in window, 2 window just closed
  int mode, m_rl, m_wl, seen, cur, zc, oc;
  bit last_b;
  bit e_busy, e_level, e_hit, e_hv, e_done, e_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("busy", busy, e_busy);
    chk("level", level, e_level);
    chk("hit", hit, e_hit);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("zero_cnt", zero_cnt, zc);
    chk("one_cnt", one_cnt, oc);
    if (e_hit) chk("hit_val", hit_val, e_hv);
  endtask

  task automatic model_reset();
    mode = 0; cur = 0; seen = 0; zc = 0; oc = 0; last_b = 0;
    e_busy = 0; e_level = 0; e_hit = 0; e_hv = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_edge(input bit s, input int rl, input int wl,
                            input bit xb, input bit xv, input bit ab);
    e_hit = 0; e_done = 0; e_err = 0;
    case (mode)
      0: if (s) begin
        if (rl < 2 || wl == 0) e_err = 1;
        else begin
          mode = 1; m_rl = rl; m_wl = wl; seen = 0; cur = 0;
          zc = 0; oc = 0; e_level = 0;
        end
      end
      1: if (ab) begin
        mode = 0; e_level = 0;
      end else if (xv) begin
        seen++;
        if (cur == 0 || xb != last_b) cur = 1; else cur++;
        last_b = xb;
        if (cur == m_rl) begin
          e_hit = 1; e_hv = xb;
          if (xb) oc = (oc < 255) ? oc + 1 : oc;
          else    zc = (zc < 255) ? zc + 1 : zc;
        end
        e_level = (cur >= m_rl);
        if (seen == m_wl) begin
          mode = 2; e_done = 1; e_level = 0;
        end
      end
      default: mode = 0;
    endcase
    e_busy = (mode == 1);
  endtask

  task automatic cyc(input bit s, input int rl, input int wl,
                     input bit xb, input bit xv, input bit ab = 1'b0);
    start   = s;
    run_len = rl[LEN_W-1:0];
    win_len = wl[CNT_W-1:0];
    x       = xb;
    x_valid = xv;
`ifdef RUN_WINDOW_ABORT_EN
    abort   = ab;
`endif
    @(posedge clk);
    model_edge(s, rl, wl, xb, xv, ab);
    #1;
    check_outputs();
  endtask

  task automatic window(input int rl, input int wl, input logic [31:0] pat, input int n);
    logic [31:0] p;
    p = pat;
    cyc(1, rl, wl, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, rl, wl, p[i], 1);
    cyc(0, rl, wl, 0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit xb, xv, sr, ab;
    int rl, wl;
    reset = 1'b1; start = 0; run_len = '0; win_len = '0; x = 0; x_valid = 0;
`ifdef RUN_WINDOW_ABORT_EN
    abort = 0;
`endif
    #2;
    apply_reset();

    // x = 0,0,0,0,1,1,1,0 (index 0 first)
    window(3, 8, 32'b0111_0000, 8);
    chk("t1_zero_cnt", zero_cnt, 1);
    chk("t1_one_cnt", one_cnt, 1);

    window(2, 6, 32'b11_1111, 6);
    chk("t2_one_cnt", one_cnt, 1);
    chk("t2_zero_cnt", zero_cnt, 0);

    cyc(1, 1, 8, 0, 0);
    chk("t3_err_rl", err, 1);
    cyc(1, 3, 0, 0, 0);
    chk("t3_err_wl", err, 1);
    chk("t3_busy", busy, 0);
    cyc(0, 3, 0, 0, 0);
    chk("t3_one_kept", one_cnt, 1);

    cyc(1, 2, 4, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 2, 4, 0, (i % 2) == 0);
    chk("t4_zero_cnt", zero_cnt, 1);

    cyc(1, 3, 8, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 3, 8, 0, 1);
    chk("t5_level_before_rst", level, 1);
    apply_reset();
    window(3, 8, 32'b0111_0000, 8);
    chk("t5_zero_after_rst", zero_cnt, 1);

`ifdef RUN_WINDOW_ABORT_EN
    cyc(1, 3, 10, 0, 0);
    cyc(0, 3, 10, 0, 1); cyc(0, 3, 10, 0, 1); cyc(0, 3, 10, 0, 1);
    cyc(0, 3, 10, 1, 1); cyc(0, 3, 10, 1, 1);
    cyc(0, 3, 10, 1, 1, 1);
    chk("ab_busy", busy, 0);
    chk("ab_zero_kept", zero_cnt, 1);
    cyc(0, 3, 10, 0, 0);
    chk("ab_no_done", done, 0);
`endif

    for (int w = 0; w < 30; w++) begin
      rl = $urandom_range(1, 6);
      wl = $urandom_range(0, 24);
      cyc(1, rl, wl, 0, 0);
      xb = $urandom_range(0, 1);
      for (int c = 0; c < 300 && mode != 0; c++) begin
        if ($urandom_range(0, 3) == 0) xb = ~xb;
        xv = ($urandom_range(0, 3) != 0);
        sr = ($urandom_range(0, 9) == 0);
`ifdef RUN_WINDOW_ABORT_EN
        ab = ($urandom_range(0, 39) == 0);
`else
        ab = 1'b0;
`endif
        cyc(sr, $urandom_range(0, 15), $urandom_range(0, 255), xb, xv, ab);
      end
      if (mode != 0) chk("rand_window_timeout", mode, 0);
      cyc(0, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
